key_msg_sender: RTL and testbench

KEY_MSG_SENDER -- requirements
Module: key_msg_sender

---
 rtl/key_msg_sender.sv | 191 +++++++++++++++++++
 tb/tb_key_msg_sender.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_msg_sender.sv
// Purpose: debounces NUM_KEYS pushbuttons and streams the per-key message slot out as bytes.
// Latency: first tx_valid 2 cycles after a key's pending bit sets, plus 1 cycle per leading NUL.
// Backpressure: a valid byte holds until tx_ready; further presses only queue as pending bits.
module key_msg_sender #(
   parameter int NUM_KEYS        = 4,
   parameter int MSG_LEN         = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_CYCLES   = 25000000,
   parameter logic [NUM_KEYS*MSG_LEN*8-1:0] MSG_TABLE = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic [2:0]          active_key,
   output logic [NUM_KEYS-1:0] key_state
);

   localparam int IW    = $clog2(MSG_LEN);
   localparam int ISPAN = 1 << IW;
   localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   // Message table unpacked to [key][byte], byte 0 = most significant byte of the slot.
   // Padded to 8 keys and a power-of-two byte span so the index widths match exactly.
   logic [7:0] rom [8][ISPAN];

   genvar gk, gi;
   generate
      for (gk = 0; gk < 8; gk++) begin : g_key
         for (gi = 0; gi < ISPAN; gi++) begin : g_byte
            if (gk < NUM_KEYS && gi < MSG_LEN) begin : g_used
               assign rom[gk][gi] = MSG_TABLE[((gk * MSG_LEN) + (MSG_LEN - 1 - gi)) * 8 +: 8];
            end else begin : g_pad
               assign rom[gk][gi] = 8'h00;
            end
         end
      end
   endgenerate

   logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NUM_KEYS-1:0] acc_q, acc_d, pend_q, pend_d;
   logic [NUM_KEYS-1:0] press_evt, rep_evt;
   logic [DW-1:0]       db_cnt_q [NUM_KEYS];
   logic [DW-1:0]       db_cnt_d [NUM_KEYS];
   logic [RW-1:0]       rp_cnt_q [NUM_KEYS];
   logic [RW-1:0]       rp_cnt_d [NUM_KEYS];

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d, idx_nxt;
   logic [2:0]    act_q, act_d, sel;
   logic          txv_q, txv_d;
   logic [7:0]    txd_q, txd_d, cur_byte, nxt_byte;
   logic          take;

   // Synchronise (inverted to pressed=1), debounce, and generate press/repeat events per key.
   always_comb begin
      sync1_d   = ~key_n;
      sync2_d   = sync1_q;
      acc_d     = acc_q;
      press_evt = '0;
      rep_evt   = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         db_cnt_d[k] = '0;
         rp_cnt_d[k] = '0;
         if (sync2_q[k] != acc_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) begin
               acc_d[k]     = sync2_q[k];
               press_evt[k] = sync2_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DW'(1);
            end
         end
         if (REPEAT_EN != 0 && acc_q[k]) begin
            if (rp_cnt_q[k] == RP_LAST) begin
               rep_evt[k] = 1'b1;
            end else begin
               rp_cnt_d[k] = rp_cnt_q[k] + RW'(1);
            end
         end
      end
   end

   // Message FSM: pick lowest pending key, then walk its slot skipping NULs.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      act_d    = act_q;
      txv_d    = txv_q;
      txd_d    = txd_q;
      sel      = 3'd0;
      idx_nxt  = idx_q + IW'(1);
      cur_byte = rom[act_q][idx_q];
      nxt_byte = rom[act_q][idx_nxt];

      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (pend_q[k]) sel = 3'(k);
      end
      take = (state_q == IDLE) && (|pend_q);

      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = SEND;
               act_d   = sel;
               idx_d   = '0;
               txv_d   = 1'b0;
            end
         end
         SEND: begin
            if (txv_q) begin
               if (tx_ready) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     txv_d   = 1'b0;
                  end else begin
                     // Load the following byte straight away so bytes go out back to back.
                     idx_d = idx_nxt;
                     txv_d = (nxt_byte != 8'h00);
                     if (nxt_byte != 8'h00) txd_d = nxt_byte;
                  end
               end
            end else if (cur_byte != 8'h00) begin
               txv_d = 1'b1;
               txd_d = cur_byte;
            end else if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_nxt;
            end
         end
         default: state_d = IDLE;
      endcase

      // New events win over the clear of the key being taken this cycle.
      pend_d = pend_q;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (take && sel == 3'(k)) pend_d[k] = 1'b0;
      end
      pend_d = pend_d | press_evt | rep_evt;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         acc_q   <= '0;
         pend_q  <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         act_q   <= 3'd0;
         txv_q   <= 1'b0;
         txd_q   <= 8'h00;
         for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_q[k] <= '0;
            rp_cnt_q[k] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         acc_q   <= acc_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
         txv_q   <= txv_d;
         txd_q   <= txd_d;
         for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_q[k] <= db_cnt_d[k];
            rp_cnt_q[k] <= rp_cnt_d[k];
         end
      end
   end

   assign tx_data    = txd_q;
   assign tx_valid   = txv_q;
   assign busy       = (state_q == SEND);
   assign active_key = act_q;
   assign key_state  = acc_q;

endmodule

// File: tb/tb_key_msg_sender.sv
// Purpose: randomized scoreboard bench for key_msg_sender with a message-level reference model.
// Latency: expected bytes are queued at stimulus time and consumed whenever a handshake occurs.
// Backpressure: tx_ready is driven high, random, toggling or manually per scenario.
module tb_key_msg_sender;

   localparam int NK = 4;
   localparam int ML = 4;
   localparam logic [NK*ML*8-1:0] TABLE = {32'h00000000, 32'h00410042, 32'h00004F4B, 32'h48690A0D};

   typedef struct packed {
      logic [7:0] dat;
      logic [2:0] key;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_n = '1;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic [2:0]    active_key;
   logic [NK-1:0] key_state;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [31:0] slot_v [NK];

   int   rdy_mode = 0;
   logic manual_rdy = 1'b0;
   logic rdy_auto = 1'b1;

   assign tx_ready = (rdy_mode == 3) ? manual_rdy : rdy_auto;

   key_msg_sender #(
      .NUM_KEYS(NK), .MSG_LEN(ML), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1), .REPEAT_CYCLES(50), .MSG_TABLE(TABLE)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .active_key(active_key), .key_state(key_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Ready generator for the automatic modes: 0 high, 1 random, 2 toggling.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       rdy_auto = 1'($urandom_range(0, 1));
         2:       rdy_auto = ~rdy_auto;
         default: rdy_auto = 1'b1;
      endcase
   end

   // Monitor: compares every accepted byte against the scoreboard and checks hold stability.
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no output", tx_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("tx_byte", {24'd0, tx_data}, {24'd0, e.dat});
               check("active_key", {29'd0, active_key}, {29'd0, e.key});
               check("busy_with_valid", {31'd0, busy}, 32'd1);
            end
            prev_hold = 1'b0;
         end else if (tx_valid) begin
            prev_hold = 1'b1;
            prev_data = tx_data;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_keys(input logic [NK-1:0] mask, input logic lvl);
      if (lvl) key_n = key_n | mask;
      else     key_n = key_n & ~mask;
   endtask

   // Bounce pulses are at most 3 cycles, shorter than the debounce window.
   task automatic bounce_to(input logic [NK-1:0] mask, input logic lvl, input int nb);
      for (int i = 0; i < nb; i++) begin
         set_keys(mask, lvl);
         repeat ($urandom_range(1, 3)) tick();
         set_keys(mask, ~lvl);
         repeat ($urandom_range(1, 3)) tick();
      end
      set_keys(mask, lvl);
   endtask

   // Reference model: a message is its slot's bytes, MSB first, with every NUL dropped.
   task automatic push_msg(input int k);
      for (int i = 0; i < ML; i++) begin
         exp_t e;
         e.dat = 8'(slot_v[k] >> (8 * (ML - 1 - i)));
         e.key = 3'(k);
         if (e.dat != 8'h00) exp_q.push_back(e);
      end
   endtask

   // Simultaneous press of all keys in mask: they queue in ascending index order.
   task automatic press_keys(input logic [NK-1:0] mask, input int hold, input int nbp,
                             input int nbr, input int nmsg);
      for (int r = 0; r < nmsg; r++) begin
         for (int k = 0; k < NK; k++) begin
            if (mask[k]) push_msg(k);
         end
      end
      bounce_to(mask, 1'b0, nbp);
      repeat (hold) tick();
      bounce_to(mask, 1'b1, nbr);
   endtask

   task automatic wait_quiet(input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 10 && n < 3000) begin
         tick();
         n++;
         if (exp_q.size() == 0 && !busy) quiet++;
         else quiet = 0;
      end
      checks++;
      if (quiet < 10) begin
         errors++;
         $display("FAIL drain_%s: got %0d bytes outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int n, lat, run, busy_n;
      int kk;
      logic [NK-1:0] m;

      slot_v[0] = 32'h48690A0D;
      slot_v[1] = 32'h00004F4B;
      slot_v[2] = 32'h00410042;
      slot_v[3] = 32'h00000000;

      // Reset state
      repeat (3) tick();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_active_key", {29'd0, active_key}, 32'd0);
      check("rst_key_state", {28'd0, key_state}, 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Key0 with bounce, ready high: back-to-back bytes, 2-cycle latency
      rdy_mode = 0;
      push_msg(0);
      bounce_to(4'b0001, 1'b0, 3);
      n = 0;
      while (!key_state[0] && n < 50) begin tick(); n++; end
      check("key_state_press", {28'd0, key_state}, 32'b0001);
      lat = 0;
      while (!tx_valid && lat < 20) begin tick(); lat++; end
      check("latency_slot0", lat, 2);
      run = 0;
      while (tx_valid && run < 20) begin tick(); run++; end
      check("run_slot0", run, 4);
      check("busy_fall", {31'd0, busy}, 32'd0);
      key_n = '1;
      wait_quiet("slot0");

      // Key1, toggling ready: two leading NULs add two cycles
      rdy_mode = 2;
      push_msg(1);
      key_n[1] = 1'b0;
      n = 0;
      while (!key_state[1] && n < 50) begin tick(); n++; end
      lat = 0;
      while (!tx_valid && lat < 20) begin tick(); lat++; end
      check("latency_slot1", lat, 4);
      key_n = '1;
      wait_quiet("slot1");

      // Keys 1 and 0 on the same cycle, random ready
      rdy_mode = 1;
      press_keys(4'b0011, 15, 2, 2, 1);
      wait_quiet("keys01");

      // All-NUL slot: busy for exactly MSG_LEN cycles, nothing sent
      rdy_mode = 0;
      key_n[3] = 1'b0;
      n = 0;
      while (!busy && n < 50) begin tick(); n++; end
      busy_n = 0;
      while (busy && busy_n < 20) begin tick(); busy_n++; end
      check("nul_slot_busy", busy_n, ML);
      key_n = '1;
      wait_quiet("slot3");

      // Press during SEND does not interrupt: key2 message first, then key0
      rdy_mode = 1;
      push_msg(2);
      push_msg(0);
      key_n[2] = 1'b0;
      repeat (3) tick();
      key_n[0] = 1'b0;
      repeat (15) tick();
      key_n = '1;
      wait_quiet("during_send");

      // Auto-repeat: 120 cycles held -> press plus two repeats
      rdy_mode = 0;
      press_keys(4'b0001, 120, 0, 0, 3);
      wait_quiet("repeat_directed");
      for (int it = 0; it < 2; it++) begin
         kk = int'($urandom_range(0, 2));
         m = 4'(1 << kk);
         rdy_mode = int'($urandom_range(0, 2));
         press_keys(m, int'($urandom_range(110, 140)), int'($urandom_range(0, 2)), 0, 3);
         wait_quiet("repeat_random");
      end

      // Randomized short presses of random key sets
      for (int it = 0; it < 12; it++) begin
         m = 4'($urandom_range(1, 15));
         rdy_mode = int'($urandom_range(0, 2));
         press_keys(m, int'($urandom_range(12, 25)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1);
         wait_quiet("random");
      end

      // Reset while byte 0x69 waits with ready low
      rdy_mode = 3;
      manual_rdy = 1'b0;
      push_msg(0);
      key_n[0] = 1'b0;
      n = 0;
      while (!tx_valid && n < 30) begin tick(); n++; end
      key_n = '1;
      check("mid_first_byte", {24'd0, tx_data}, 32'h48);
      manual_rdy = 1'b1;
      tick();
      manual_rdy = 1'b0;
      tick();
      check("mid_pending_valid", {31'd0, tx_valid}, 32'd1);
      check("mid_pending_byte", {24'd0, tx_data}, 32'h69);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_active", {29'd0, active_key}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy || tx_valid) busy_n++;
      end
      check("no_pending_after_rst", busy_n, 0);
      manual_rdy = 1'b1;
      press_keys(4'b0001, 15, 1, 1, 1);
      wait_quiet("restart");

      // Key held through reset: exactly one message afterwards
      rdy_mode = 0;
      push_msg(1);
      key_n[1] = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (15) tick();
      key_n = '1;
      wait_quiet("held_through_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
